// File: rtl/end_frame_encoder.sv
// rtl/end_frame_encoder.sv - Maple bus end-of-frame pattern generator (optional macro: MAPLE_EOF_OE_EN)
module end_frame_encoder #(
    parameter int TICK_DIV = 4,
    parameter int CNT_W    = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic sdcka_out,
    output logic sdckb_out,
`ifdef MAPLE_EOF_OE_EN
    output logic sdcka_oe,
    output logic sdckb_oe,
`endif
    output logic busy,
    output logic done
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        B_FALL  = 3'd1,
        A_LOW1  = 3'd2,
        A_HIGH1 = 3'd3,
        A_LOW2  = 3'd4,
        A_HIGH2 = 3'd5,
        B_RISE  = 3'd6,
        DONE    = 3'd7
    } state_t;

    // Phase states are encoded consecutively so "next phase" is state + 1.
    localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(TICK_DIV - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sdcka_d, sdckb_d, busy_d, done_d;

    // Next state and phase-hold counter; start is only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start) begin
                    state_d = B_FALL;
                end
            end
            DONE: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                if (cnt_q == LAST_TICK) begin
                    cnt_d   = '0;
                    state_d = state_t'(state_q + 3'd1);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    // Output levels decoded from the next state so the registered outputs line up with the state register.
    always_comb begin
        sdcka_d = !((state_d == A_LOW1) || (state_d == A_LOW2));
        sdckb_d = (state_d == IDLE) || (state_d == B_RISE) || (state_d == DONE);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
    end

    // State, counter and all bus/status outputs; reset drops the bus to idle-high immediately.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sdcka_out <= 1'b1;
            sdckb_out <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef MAPLE_EOF_OE_EN
            sdcka_oe  <= 1'b0;
            sdckb_oe  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sdcka_out <= sdcka_d;
            sdckb_out <= sdckb_d;
            busy      <= busy_d;
            done      <= done_d;
`ifdef MAPLE_EOF_OE_EN
            sdcka_oe  <= busy_d;
            sdckb_oe  <= busy_d;
`endif
        end
    end

endmodule
